care_scheduler: RTL and testbench

Sequences care actions into the pet-stats block. Arbitrates between the push-button decoder and the UART keyboard byte stream, decodes ASCII command bytes, filters actions against the sleep and death state, and issues exactly one single-cycle action strobe per accepted request. After each strobe it enforces a cooldown measured in one-second ticks. It sits between the input front-ends and the stats/animation logic.

---
 rtl/care_pkg.sv | 27 ++
 rtl/care_decode.sv | 22 ++
 rtl/care_scheduler.sv | 122 ++++++++++++
 tb/tb_care_scheduler.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/care_pkg.sv
// Shared definitions for the care action path: action codes, ASCII command bytes, scheduler states.
package care_pkg;

  typedef enum logic [2:0] {
    ACT_NONE  = 3'd0,
    ACT_FEED  = 3'd1,
    ACT_PLAY  = 3'd2,
    ACT_HEAL  = 3'd3,
    ACT_CLEAN = 3'd4,
    ACT_SLEEP = 3'd5,
    ACT_WAKE  = 3'd6
  } action_t;

  localparam logic [7:0] ASCII_FEED  = 8'h65; // 'e'
  localparam logic [7:0] ASCII_PLAY  = 8'h70; // 'p'
  localparam logic [7:0] ASCII_HEAL  = 8'h64; // 'd'
  localparam logic [7:0] ASCII_CLEAN = 8'h62; // 'b'
  localparam logic [7:0] ASCII_SLEEP = 8'h73; // 's'
  localparam logic [7:0] ASCII_WAKE  = 8'h77; // 'w'

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_COOLDOWN = 2'd2
  } state_t;

endpackage

// File: rtl/care_decode.sv
// Combinational ASCII command byte to action decoder; unknown bytes map to NONE.
module care_decode
  import care_pkg::*;
(
  input  logic [7:0] cmd_byte,
  output action_t    act
);

  always_comb begin
    act = ACT_NONE;
    case (cmd_byte)
      ASCII_FEED:  act = ACT_FEED;
      ASCII_PLAY:  act = ACT_PLAY;
      ASCII_HEAL:  act = ACT_HEAL;
      ASCII_CLEAN: act = ACT_CLEAN;
      ASCII_SLEEP: act = ACT_SLEEP;
      ASCII_WAKE:  act = ACT_WAKE;
      default:     act = ACT_NONE;
    endcase
  end

endmodule

// File: rtl/care_scheduler.sv
// Arbitrates button/UART care requests, filters against sleep/death, issues one strobe then cools down.
// Optional CARE_SCHED_AUTOWAKE_EN adds an internal top-priority WAKE requester.
module care_scheduler
  import care_pkg::*;
#(
  parameter int COOLDOWN_TICKS = 2,
  parameter int CNT_W          = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       btn_valid,
  input  logic [2:0] btn_action,
  output logic       btn_ready,
  input  logic       uart_valid,
  input  logic [7:0] uart_byte,
  output logic       uart_ready,
  input  logic       is_sleeping,
  input  logic       dead,
  input  logic [4:0] energy,
  output logic       act_valid,
  output logic [2:0] act_code,
  output logic       busy,
  output logic [7:0] drop_cnt
);

  state_t           state_q, state_d;
  action_t          code_q, code_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       drop_q, drop_d;
  logic             rr_uart_q, rr_uart_d; // 1: UART was granted last, so button wins the next tie

  action_t uart_act;
  action_t req_act;
  logic    idle, tie, aw_fire, btn_acc, uart_acc, pass;

  care_decode u_decode (
    .cmd_byte (uart_byte),
    .act      (uart_act)
  );

`ifdef CARE_SCHED_AUTOWAKE_EN
  assign aw_fire = (state_q == ST_IDLE) && tick && is_sleeping && !dead && (energy == 5'd0);
`else
  logic unused_energy;
  assign unused_energy = ^energy;
  assign aw_fire = 1'b0;
`endif

  assign idle       = (state_q == ST_IDLE);
  assign tie        = btn_valid && uart_valid;
  assign btn_ready  = idle && !aw_fire && !(tie && !rr_uart_q);
  assign uart_ready = idle && !aw_fire && !(tie && rr_uart_q);
  assign btn_acc    = btn_valid && btn_ready;
  assign uart_acc   = uart_valid && uart_ready;

  always_comb begin
    req_act = ACT_NONE;
    if (btn_acc)       req_act = action_t'(btn_action);
    else if (uart_acc) req_act = uart_act;
  end

  // Sleeping pets only accept WAKE; awake pets never accept WAKE.
  assign pass = (req_act != ACT_NONE) && !dead &&
                (is_sleeping ? (req_act == ACT_WAKE) : (req_act != ACT_WAKE));

  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    cnt_d     = cnt_q;
    drop_d    = drop_q;
    rr_uart_d = rr_uart_q;
    case (state_q)
      ST_IDLE: begin
        if (btn_acc)  rr_uart_d = 1'b0;
        if (uart_acc) rr_uart_d = 1'b1;
        if (aw_fire) begin
          code_d  = ACT_WAKE;
          state_d = ST_ISSUE;
        end else if (btn_acc || uart_acc) begin
          if (pass) begin
            code_d  = req_act;
            state_d = ST_ISSUE;
          end else if (drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
          end
        end
      end
      ST_ISSUE: begin
        cnt_d   = CNT_W'(COOLDOWN_TICKS);
        state_d = (COOLDOWN_TICKS == 0) ? ST_IDLE : ST_COOLDOWN;
      end
      ST_COOLDOWN: begin
        if (cnt_q == '0)  state_d = ST_IDLE;
        else if (tick)    cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      code_q    <= ACT_NONE;
      cnt_q     <= '0;
      drop_q    <= '0;
      rr_uart_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      cnt_q     <= cnt_d;
      drop_q    <= drop_d;
      rr_uart_q <= rr_uart_d;
    end
  end

  assign act_valid = (state_q == ST_ISSUE);
  assign act_code  = code_q;
  assign busy      = !idle;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_care_scheduler.sv
// Directed self-checking bench for care_scheduler (default parameters, COOLDOWN_TICKS=2).
module tb_care_scheduler;

  logic       clk = 1'b0;
  logic       reset, tick, btn_valid, uart_valid, is_sleeping, dead;
  logic [2:0] btn_action;
  logic [7:0] uart_byte;
  logic [4:0] energy;
  logic       btn_ready, uart_ready, act_valid, busy;
  logic [2:0] act_code;
  logic [7:0] drop_cnt;

  int checks = 0;
  int errors = 0;
  int strobes;

  always #5 clk = ~clk;

  care_scheduler dut (
    .clk(clk), .reset(reset), .tick(tick),
    .btn_valid(btn_valid), .btn_action(btn_action), .btn_ready(btn_ready),
    .uart_valid(uart_valid), .uart_byte(uart_byte), .uart_ready(uart_ready),
    .is_sleeping(is_sleeping), .dead(dead), .energy(energy),
    .act_valid(act_valid), .act_code(act_code), .busy(busy), .drop_cnt(drop_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are changed and outputs sampled here.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Supply ticks during cooldown until the block is idle again, with a bounded budget.
  task automatic wait_idle(input string tag);
    for (int i = 0; i < 20 && busy; i++) begin
      tick = 1'b1; cyc(); tick = 1'b0; cyc();
    end
    check(tag, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; btn_valid = 1'b0; uart_valid = 1'b0;
    btn_action = 3'd0; uart_byte = 8'h00; is_sleeping = 1'b0; dead = 1'b0; energy = 5'd10;
    cyc(); cyc();
    reset = 1'b0;
    cyc();
    check("rst_act_valid", {31'd0, act_valid}, 32'd0);
    check("rst_act_code", {29'd0, act_code}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_drop", {24'd0, drop_cnt}, 32'd0);
    check("rst_readies", {30'd0, btn_ready, uart_ready}, 32'd3);

    // UART 'e' -> FEED, then cooldown of two ticks
    uart_valid = 1'b1; uart_byte = 8'h65;
    #1 check("feed_uart_ready", {31'd0, uart_ready}, 32'd1);
    cyc(); uart_valid = 1'b0;
    check("feed_strobe", {31'd0, act_valid}, 32'd1);
    check("feed_code", {29'd0, act_code}, 32'd1);
    check("feed_busy", {31'd0, busy}, 32'd1);
    check("issue_readies", {30'd0, btn_ready, uart_ready}, 32'd0);
    cyc();
    check("cd_no_strobe", {31'd0, act_valid}, 32'd0);
    check("cd_readies", {30'd0, btn_ready, uart_ready}, 32'd0);
    cyc(); cyc();
    check("cd_waits_tick", {31'd0, busy}, 32'd1);
    tick = 1'b1; cyc(); tick = 1'b0;
    cyc();
    check("cd_after_1tick", {31'd0, busy}, 32'd1);
    tick = 1'b1; cyc(); tick = 1'b0;
    check("cd_cnt_zero_still_busy", {31'd0, busy}, 32'd1);
    cyc();
    check("cd_done_idle", {31'd0, busy}, 32'd0);
    check("cd_done_readies", {30'd0, btn_ready, uart_ready}, 32'd3);
    check("code_held", {29'd0, act_code}, 32'd1);

    // Round-robin: UART was granted last, so the button wins first
    btn_valid = 1'b1; btn_action = 3'd2; uart_valid = 1'b1; uart_byte = 8'h64;
    #1 check("rr1_readies", {30'd0, btn_ready, uart_ready}, 32'd2);
    cyc(); btn_valid = 1'b0; uart_valid = 1'b0;
    check("rr1_code", {29'd0, act_code}, 32'd2);
    check("rr1_strobe", {31'd0, act_valid}, 32'd1);
    wait_idle("rr1_timeout");
    btn_valid = 1'b1; uart_valid = 1'b1;
    #1 check("rr2_readies", {30'd0, btn_ready, uart_ready}, 32'd1);
    cyc(); btn_valid = 1'b0; uart_valid = 1'b0;
    check("rr2_code", {29'd0, act_code}, 32'd3);
    wait_idle("rr2_timeout");
    btn_valid = 1'b1; uart_valid = 1'b1;
    #1 check("rr3_readies", {30'd0, btn_ready, uart_ready}, 32'd2);
    cyc(); btn_valid = 1'b0; uart_valid = 1'b0;
    check("rr3_code", {29'd0, act_code}, 32'd2);
    wait_idle("rr3_timeout");

    // Sleep filter
    is_sleeping = 1'b1; uart_valid = 1'b1; uart_byte = 8'h70;
    cyc(); uart_valid = 1'b0;
    check("sleep_play_dropped", {31'd0, act_valid}, 32'd0);
    check("sleep_play_idle", {31'd0, busy}, 32'd0);
    check("sleep_drop1", {24'd0, drop_cnt}, 32'd1);
    uart_valid = 1'b1; uart_byte = 8'h77;
    cyc(); uart_valid = 1'b0;
    check("wake_strobe", {31'd0, act_valid}, 32'd1);
    check("wake_code", {29'd0, act_code}, 32'd6);
    wait_idle("wake_timeout");
    is_sleeping = 1'b0;
    uart_valid = 1'b1; uart_byte = 8'h77;
    cyc(); uart_byte = 8'h41;
    check("awake_wake_dropped", {24'd0, drop_cnt}, 32'd2);
    cyc(); uart_valid = 1'b0;
    check("unknown_byte_dropped", {24'd0, drop_cnt}, 32'd3);
    check("unknown_byte_no_strobe", {31'd0, act_valid}, 32'd0);

    // Dead pet: 300 spaced requests, counter saturates
    dead = 1'b1; btn_action = 3'd1; strobes = 0;
    for (int i = 0; i < 300; i++) begin
      btn_valid = 1'b1; cyc(); btn_valid = 1'b0;
      if (act_valid) strobes++;
      cyc();
    end
    check("dead_no_strobe", strobes, 32'd0);
    check("dead_drop_sat", {24'd0, drop_cnt}, 32'd255);
    dead = 1'b0;

    // Reset during cooldown
    btn_valid = 1'b1; btn_action = 3'd4;
    cyc(); btn_valid = 1'b0;
    check("clean_code", {29'd0, act_code}, 32'd4);
    cyc();
    tick = 1'b1; cyc(); tick = 1'b0;
    reset = 1'b1; cyc(); reset = 1'b0;
    check("rst_cd_busy", {31'd0, busy}, 32'd0);
    check("rst_cd_readies", {30'd0, btn_ready, uart_ready}, 32'd3);
    check("rst_cd_code", {29'd0, act_code}, 32'd0);
    check("rst_cd_drop", {24'd0, drop_cnt}, 32'd0);

    // Reset while a strobe is showing: next cycle it is gone
    btn_valid = 1'b1; btn_action = 3'd1;
    cyc(); btn_valid = 1'b0;
    check("pre_rst_strobe", {31'd0, act_valid}, 32'd1);
    reset = 1'b1; cyc(); reset = 1'b0;
    check("rst_issue_strobe", {31'd0, act_valid}, 32'd0);
    check("rst_issue_busy", {31'd0, busy}, 32'd0);
    cyc();

    // Sleeping, zero energy, tick with no external request
    is_sleeping = 1'b1; energy = 5'd0; tick = 1'b1;
`ifdef CARE_SCHED_AUTOWAKE_EN
    #1 check("aw_readies", {30'd0, btn_ready, uart_ready}, 32'd0);
    cyc(); tick = 1'b0;
    check("aw_strobe", {31'd0, act_valid}, 32'd1);
    check("aw_code", {29'd0, act_code}, 32'd6);
    wait_idle("aw_timeout");
`else
    cyc(); tick = 1'b0;
    check("no_aw_strobe", {31'd0, act_valid}, 32'd0);
    check("no_aw_busy", {31'd0, busy}, 32'd0);
`endif
    is_sleeping = 1'b0; energy = 5'd10;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
